// File: rtl/ifetch_core_if.sv
// ifetch_core_if: groups the instruction-ROM port, the redirect input from
// execute, the decode-side valid/ready handshake and the fault flag.
//   master : the fetch unit (drives imem_en/imem_pc, out_*, fetch_fault)
//   slave  : the environment (ROM, execute, decode)
interface ifetch_core_if;
  logic        imem_en;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        fetch_fault;

  modport master (
    output imem_en, imem_pc, out_valid, out_pc, out_instr, fetch_fault,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_en, imem_pc, out_valid, out_pc, out_instr, fetch_fault,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_core.sv
// ifetch_core: instruction-fetch initiator for one core.
// Owns the PC, issues reads to a synchronous ROM (data one cycle after the
// request), pairs each returned word with its PC, buffers the pairs in a
// small FIFO and presents the head to decode over valid/ready. A redirect
// from execute flushes buffered and in-flight words and refetches at once.
//
// Ports:
//   clk  - core clock
//   rst  - synchronous active-high reset
//   bus  - ifetch_core_if.master: imem_en/imem_pc/imem_instr (ROM),
//          redirect_valid/redirect_pc (execute), out_valid/out_pc/
//          out_instr/out_ready (decode), fetch_fault
//
// Parameters:
//   RESET_PC   - first fetch address after reset
//   FIFO_DEPTH - (pc, instr) buffer entries, power of two, >= 2
//
// Optional build macro IFETCH_MISALIGN_TRAP_EN: a redirect to a non
// word-aligned target parks the unit in a FAULT state with a sticky
// fetch_fault until an aligned redirect or reset. Without it the low two
// target bits are cleared and fetch_fault is tied 0.
module ifetch_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_core_if.master bus
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  // One extra bit so occupancy + credit arithmetic cannot overflow.
  localparam int CW   = AW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  logic [0:0] state_q, state_d;
`endif

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]     fifo_pc_d    [FIFO_DEPTH];
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [31:0]     fifo_instr_d [FIFO_DEPTH];

  logic            redirect;
  logic            misaligned;
  logic            in_fault;
  logic            has_head;
  logic            out_valid;
  logic            pop;
  logic            push;
  logic            flush;
  logic            issue;
  logic [31:0]     target;
  logic [31:0]     issue_pc;
  logic [CW-1:0]   occupancy;
  logic [CW-1:0]   limit;

  always_comb begin
    redirect = bus.redirect_valid;
    // Masking (rather than slicing) keeps every redirect_pc bit in use.
    target   = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef IFETCH_MISALIGN_TRAP_EN
    state_d    = state_q;
    misaligned = redirect && (bus.redirect_pc[1:0] != 2'b00);
    in_fault   = (state_q == ST_FAULT);
`else
    misaligned = 1'b0;
    in_fault   = 1'b0;
`endif

    // Head presentation: zeros when empty, forced invalid during a redirect.
    has_head      = (count_q != '0);
    bus.out_pc    = has_head ? fifo_pc_q[rd_ptr_q]    : 32'h0;
    bus.out_instr = has_head ? fifo_instr_q[rd_ptr_q] : 32'h0;
    out_valid     = !rst && !redirect && !in_fault && has_head;
    bus.out_valid = out_valid;
    pop           = out_valid && bus.out_ready;

    // Credit: words buffered plus the one in flight, less the one leaving
    // this cycle, must leave room for the word we are about to request.
    occupancy = CW'(count_q) + CW'(inflight_q);
    limit     = DEPTH_C + CW'(pop);

    issue      = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    issue_pc   = fetch_pc_q;
    fetch_pc_d = fetch_pc_q;

    if (redirect) begin
      // Everything older than the redirect is wrong-path: drop it, including
      // the response landing this cycle.
      flush = 1'b1;
      if (misaligned) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
        state_d    = ST_FAULT;
        fetch_pc_d = bus.redirect_pc;
`endif
      end else begin
`ifdef IFETCH_MISALIGN_TRAP_EN
        state_d = ST_RUN;
`endif
        issue      = 1'b1;
        issue_pc   = target;
        fetch_pc_d = target + 32'd4;
      end
    end else if (!in_fault) begin
      push  = inflight_q;
      issue = (occupancy < limit);
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end

    bus.imem_en     = issue && !rst;
    bus.imem_pc     = issue_pc;
    bus.fetch_fault = !rst && (in_fault || misaligned);

    inflight_d = issue;
    req_pc_d   = issue ? issue_pc : req_pc_q;

    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = req_pc_q;
        fifo_instr_d[wr_ptr_q] = bus.imem_instr;
        wr_ptr_d               = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  // ---- register stage: control state (reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      state_q    <= ST_RUN;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      state_q    <= state_d;
`endif
    end
  end

  // ---- register stage: datapath (no reset, qualified by control) ----
  always_ff @(posedge clk) begin
    req_pc_q     <= req_pc_d;
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

endmodule

// File: tb/tb_ifetch_core.sv
module tb_ifetch_core;

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  always #5 clk = ~clk;

  ifetch_core_if bus0 ();
  ifetch_core_if bus1 ();

  assign bus0.redirect_valid = redirect_valid;
  assign bus0.redirect_pc    = redirect_pc;
  assign bus0.out_ready      = out_ready;
  assign bus1.redirect_valid = redirect_valid;
  assign bus1.redirect_pc    = redirect_pc;
  assign bus1.out_ready      = out_ready;

  ifetch_core #(.RESET_PC(RPC0), .FIFO_DEPTH(DEPTH)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ifetch_core #(.RESET_PC(RPC1), .FIFO_DEPTH(DEPTH)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h00: rom_word = 32'h0010_0313;
      32'h04: rom_word = 32'h0020_0393;
      32'h08: rom_word = 32'h0076_0433;
      32'h0C: rom_word = 32'h4063_8433;
      32'h10: rom_word = 32'h0030_0513;
      32'h14: rom_word = 32'h00A5_05B3;
      32'h18: rom_word = 32'hFE00_006F;
      default: rom_word = 32'hC0DE_0000 ^ a;
    endcase
  endfunction

  // Synchronous-read ROMs
  always @(posedge clk) begin
    if (bus0.imem_en) bus0.imem_instr <= rom_word(bus0.imem_pc);
    if (bus1.imem_en) bus1.imem_instr <= rom_word(bus1.imem_pc);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per DUT: an ordered list of requested PCs with the cycle each was
  // requested; a word becomes visible two cycles after its request, decode
  // consumes from the front, a redirect empties the list.
  logic [31:0] q_pc   [2][16];
  int          q_cyc  [2][16];
  int          q_n    [2];
  logic [31:0] nxt    [2];
  bit          flt    [2];
  logic [31:0] got_pc [2][256];
  logic [31:0] got_in [2][256];
  int          got_n  [2];
  int          first_en  [2];
  int          first_val [2];
  int          cyc = 0;
  int          rel_cyc = -1;
  bit          prev_rst = 1'b1;

  initial begin
    got_n[0] = 0;
    got_n[1] = 0;
  end

  always @(negedge clk) begin
    logic        ov [2];
    logic [31:0] opc [2];
    logic [31:0] oin [2];
    logic        en [2];
    logic [31:0] ipc [2];
    logic        ff [2];
    logic        mis, expv, popv, expen;
    logic [31:0] exppc;
    cyc++;
    ov[0] = bus0.out_valid; opc[0] = bus0.out_pc; oin[0] = bus0.out_instr;
    en[0] = bus0.imem_en;   ipc[0] = bus0.imem_pc; ff[0] = bus0.fetch_fault;
    ov[1] = bus1.out_valid; opc[1] = bus1.out_pc; oin[1] = bus1.out_instr;
    en[1] = bus1.imem_en;   ipc[1] = bus1.imem_pc; ff[1] = bus1.fetch_fault;
    if (!rst && prev_rst) begin
      rel_cyc = cyc;
      first_en[0] = -1; first_en[1] = -1;
      first_val[0] = -1; first_val[1] = -1;
    end
    prev_rst = rst;
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        check($sformatf("dut%0d rst out_valid", g), 32'(ov[g]), 32'h0);
        check($sformatf("dut%0d rst imem_en", g), 32'(en[g]), 32'h0);
        check($sformatf("dut%0d rst fetch_fault", g), 32'(ff[g]), 32'h0);
        q_n[g] = 0;
        nxt[g] = (g == 0) ? RPC0 : RPC1;
        flt[g] = 1'b0;
      end else begin
        mis  = TRAP && redirect_valid && (redirect_pc[1:0] != 2'b00);
        expv = !redirect_valid && !flt[g] && (q_n[g] > 0) && (q_cyc[g][0] + 2 <= cyc);
        check($sformatf("dut%0d out_valid c%0d", g, cyc), 32'(ov[g]), 32'(expv));
        if (expv) begin
          check($sformatf("dut%0d out_pc c%0d", g, cyc), opc[g], q_pc[g][0]);
          check($sformatf("dut%0d out_instr c%0d", g, cyc), oin[g], rom_word(q_pc[g][0]));
        end
        popv = expv && out_ready;
        if (redirect_valid) begin
          expen = !mis;
          exppc = redirect_pc & 32'hFFFF_FFFC;
        end else if (flt[g]) begin
          expen = 1'b0;
          exppc = nxt[g];
        end else begin
          expen = ((q_n[g] - int'(popv)) < DEPTH);
          exppc = nxt[g];
        end
        check($sformatf("dut%0d imem_en c%0d", g, cyc), 32'(en[g]), 32'(expen));
        if (expen) check($sformatf("dut%0d imem_pc c%0d", g, cyc), ipc[g], exppc);
        check($sformatf("dut%0d fetch_fault c%0d", g, cyc), 32'(ff[g]), 32'(flt[g] || mis));
        if (first_en[g] < 0 && en[g]) first_en[g] = cyc;
        if (first_val[g] < 0 && ov[g]) first_val[g] = cyc;
        // state update for the coming edge
        if (redirect_valid) begin
          q_n[g] = 0;
          flt[g] = mis;
          if (mis) nxt[g] = redirect_pc;
        end
        if (popv) begin
          if (got_n[g] < 256) begin
            got_pc[g][got_n[g]] = q_pc[g][0];
            got_in[g][got_n[g]] = oin[g];
            got_n[g]++;
          end
          for (int k = 0; k < 15; k++) begin
            q_pc[g][k]  = q_pc[g][k+1];
            q_cyc[g][k] = q_cyc[g][k+1];
          end
          q_n[g]--;
        end
        if (expen && q_n[g] < 16) begin
          q_pc[g][q_n[g]]  = exppc;
          q_cyc[g][q_n[g]] = cyc;
          q_n[g]++;
          nxt[g] = exppc + 32'd4;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int b0, b1;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;

    // Power-up, free-running decode
    tick(3);
    rst = 1'b0;
    b0 = got_n[0]; b1 = got_n[1];
    tick(8);
    check("first fetch cycle", 32'(first_en[0]), 32'(rel_cyc));
    check("first valid cycle", 32'(first_val[0]), 32'(rel_cyc + 2));
    check("stream pc0", got_pc[0][b0], 32'h0);
    check("stream in0", got_in[0][b0], 32'h0010_0313);
    check("stream pc1", got_pc[0][b0+1], 32'h4);
    check("stream in1", got_in[0][b0+1], 32'h0020_0393);
    check("stream pc2", got_pc[0][b0+2], 32'h8);
    check("stream in2", got_in[0][b0+2], 32'h0076_0433);
    check("wrap pc0", got_pc[1][b1], 32'hFFFF_FFF8);
    check("wrap pc1", got_pc[1][b1+1], 32'hFFFF_FFFC);
    check("wrap pc2", got_pc[1][b1+2], 32'h0000_0000);
    check("wrap pc3", got_pc[1][b1+3], 32'h0000_0004);
    check("wrap in2", got_in[1][b1+2], 32'h0010_0313);

    // Reset mid-stream, then decode stalled for 6 cycles after first valid
    rst = 1'b1; out_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    b0 = got_n[0];
    tick(5);
    #2;
    check("stall imem_en", 32'(bus0.imem_en), 32'h0);
    check("stall out_valid", 32'(bus0.out_valid), 32'h1);
    check("stall head pc", bus0.out_pc, 32'h0);
    check("stall head instr", bus0.out_instr, 32'h0010_0313);
    tick(3);
    check("stall no pop", 32'(got_n[0] - b0), 32'h0);
    out_ready = 1'b1;
    tick(6);
    check("resume pc0", got_pc[0][b0], 32'h0);
    check("resume pc1", got_pc[0][b0+1], 32'h4);
    check("resume pc2", got_pc[0][b0+2], 32'h8);
    check("resume pc3", got_pc[0][b0+3], 32'hC);
    check("resume in3", got_in[0][b0+3], 32'h4063_8433);

    // Redirect while stalled with a full buffer
    out_ready = 1'b0;
    tick(4);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    #2;
    check("redir out_valid", 32'(bus0.out_valid), 32'h0);
    check("redir imem_en", 32'(bus0.imem_en), 32'h1);
    check("redir imem_pc", bus0.imem_pc, 32'h10);
    tick(1);
    redirect_valid = 1'b0; out_ready = 1'b1;
    b0 = got_n[0];
    tick(5);
    check("redir pc0", got_pc[0][b0], 32'h10);
    check("redir in0", got_in[0][b0], 32'h0030_0513);
    check("redir pc1", got_pc[0][b0+1], 32'h14);
    check("redir in1", got_in[0][b0+1], 32'h00A5_05B3);

    // Redirect against a valid head with decode ready
    b0 = got_n[0];
    redirect_valid = 1'b1; redirect_pc = 32'h4;
    #2;
    check("redir-ready out_valid", 32'(bus0.out_valid), 32'h0);
    tick(1);
    redirect_valid = 1'b0;
    tick(4);
    check("redir-ready next pc", got_pc[0][b0], 32'h4);

    // Back-to-back redirects: last wins
    b0 = got_n[0];
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick(1);
    redirect_pc = 32'h18;
    tick(1);
    redirect_valid = 1'b0;
    tick(4);
    check("b2b pc", got_pc[0][b0], 32'h18);
    check("b2b instr", got_in[0][b0], 32'hFE00_006F);

    // Misaligned redirect
    b0 = got_n[0];
    redirect_valid = 1'b1; redirect_pc = 32'h12;
    #2;
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("mis fault", 32'(bus0.fetch_fault), 32'h1);
    check("mis imem_en", 32'(bus0.imem_en), 32'h0);
`else
    check("mis imem_en", 32'(bus0.imem_en), 32'h1);
    check("mis imem_pc", bus0.imem_pc, 32'h10);
`endif
    tick(1);
    redirect_valid = 1'b0;
    tick(3);
    #2;
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("fault sticky", 32'(bus0.fetch_fault), 32'h1);
    check("fault out_valid", 32'(bus0.out_valid), 32'h0);
    check("fault imem_en", 32'(bus0.imem_en), 32'h0);
    check("fault no output", 32'(got_n[0] - b0), 32'h0);
    tick(1);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    #2;
    check("recover imem_en", 32'(bus0.imem_en), 32'h1);
    check("recover imem_pc", bus0.imem_pc, 32'h0);
    tick(1);
    redirect_valid = 1'b0;
    tick(4);
    check("recover pc", got_pc[0][b0], 32'h0);
    check("recover fault clear", 32'(bus0.fetch_fault), 32'h0);
`else
    check("mis no fault", 32'(bus0.fetch_fault), 32'h0);
    check("mis pc", got_pc[0][b0], 32'h10);
    check("mis pc next", got_pc[0][b0+1], 32'h14);
    tick(1);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
